// File: rtl/alu_muldiv.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/compare ops plus
// iterative signed/unsigned multiply and divide into internal HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero,
  output logic             Busy,
  output logic             Done
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_NOR = 4'b1100, OP_SLT = 4'b0111,
                         OP_SLTU = 4'b0101, OP_MULT = 4'b1000, OP_MULTU = 4'b1001,
                         OP_DIV = 4'b1010, OP_DIVU = 4'b1011, OP_MFHI = 4'b1101,
                         OP_MFLO = 4'b1110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [WIDTH-1:0]  hi, lo;
  logic [WIDTH-1:0]  m, p, q;
  logic              is_div, dz, neg_q, neg_r;

  // single-cycle datapath
  logic [WIDTH-1:0]  sum, dif, sc_res;
  logic              sc_ovf;
  assign sum = A + B;
  assign dif = A - B;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ALUControl)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_NOR:  sc_res = ~(A | B);
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, A < B};
      OP_MFHI: sc_res = hi;
      OP_MFLO: sc_res = lo;
      default: sc_res = '0;
    endcase
  end

  // operand capture: signed ops iterate on magnitudes, sign fixed up in FIN
  logic              go_mul, go_div, sgn;
  logic [WIDTH-1:0]  a_mag, b_mag;
  assign go_mul = (ALUControl == OP_MULT) || (ALUControl == OP_MULTU);
  assign go_div = (ALUControl == OP_DIV)  || (ALUControl == OP_DIVU);
  assign sgn    = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
  assign a_mag  = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag  = (sgn && B[WIDTH-1]) ? -B : B;

  // one iteration step; p = partial product high half / partial remainder
  logic [WIDTH:0]    mul_sum, r_sh, diff;
  logic [WIDTH-1:0]  nxt_p, nxt_q;
  logic              ge;
  assign mul_sum = {1'b0, p} + {1'b0, m & {WIDTH{q[0]}}};
  assign r_sh    = {p, q[WIDTH-1]};
  assign diff    = r_sh - {1'b0, m};
  assign ge      = ~diff[WIDTH];
  assign nxt_p   = is_div ? (ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
  assign nxt_q   = is_div ? {q[WIDTH-2:0], ge} : {mul_sum[0], q[WIDTH-1:1]};

  // FIN performs the last step combinationally, then corrects signs
  logic [2*WIDTH-1:0] prod_u, prod;
  logic [WIDTH-1:0]   quo, rem, hi_n, lo_n;
  assign prod_u = {nxt_p, nxt_q};
  assign prod   = neg_q ? -prod_u : prod_u;
  assign quo    = dz ? '1 : (neg_q ? -nxt_q : nxt_q);
  assign rem    = neg_r ? -nxt_p : nxt_p;
  assign hi_n   = is_div ? rem : prod[2*WIDTH-1:WIDTH];
  assign lo_n   = is_div ? quo : prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;  cnt <= '0;
      hi <= '0;  lo <= '0;  m <= '0;  p <= '0;  q <= '0;
      is_div <= 1'b0;  dz <= 1'b0;  neg_q <= 1'b0;  neg_r <= 1'b0;
      ALUResult <= '0;  Zero <= 1'b1;  Overflow <= 1'b0;  DivZero <= 1'b0;
      Busy <= 1'b0;  Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          if (go_mul || go_div) begin
            state  <= go_div ? DIV : MUL;
            Busy   <= 1'b1;
            cnt    <= CNTW'(WIDTH);
            m      <= b_mag;
            p      <= '0;
            q      <= a_mag;
            is_div <= go_div;
            dz     <= go_div && (B == '0);
            neg_q  <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= sgn && A[WIDTH-1];
          end else begin
            ALUResult <= sc_res;
            Zero      <= (sc_res == '0);
            Overflow  <= sc_ovf;
            DivZero   <= 1'b0;
            Done      <= 1'b1;
          end
        end
        MUL, DIV: begin
          p   <= nxt_p;
          q   <= nxt_q;
          cnt <= cnt - 1'b1;
          // counter reaches 1 on entry to FIN, which does the final step
          if (cnt == CNTW'(2)) state <= FIN;
        end
        FIN: begin
          hi        <= hi_n;
          lo        <= lo_n;
          ALUResult <= lo_n;
          Zero      <= (lo_n == '0);
          Overflow  <= 1'b0;
          DivZero   <= dz;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
